add_seq_initiator: RTL and testbench

ADD_SEQ_INITIATOR -- requirements
Module: add_seq_initiator

---
 rtl/add_seq_initiator.sv | 151 +++++++++++++++
 tb/tb_add_seq_initiator.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_initiator.sv
// add_seq_initiator: credit-based initiator for a pipelined adder.
// Accepts operand pairs, issues one-cycle start pulses, buffers returned sums
// in an in-order result FIFO. Credits (DEPTH - buffered - in flight) gate
// acceptance, so the FIFO can never overflow regardless of adder latency.
// Optional build macro ADD_SEQ_CHECK_EN adds an expected-sum FIFO and a
// sticky err output that flags wrong sums and unsolicited adder strobes.
module add_seq_initiator #(
    parameter int unsigned W     = 20,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         start,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    input  logic [W-1:0] y,
    input  logic         valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
`ifdef ADD_SEQ_CHECK_EN
   ,output logic         err
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Elaboration guards on the parameters; LAT is informational only.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (LAT == 0) begin : g_bad_lat
        $error("LAT must be at least 1");
    end

    logic          start_q;
    logic [W-1:0]  a_q, b_q;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [W-1:0]  mem_q [DEPTH];

    logic [CW-1:0] credits_c;
    logic          accept_c;
    logic          push_c;
    logic          pop_c;

    // Handshake qualifiers and next-state counters; a strobe with nothing in flight is dropped.
    always_comb begin
        credits_c  = CW'(DEPTH) - fifo_cnt_q - inflight_q;
        accept_c   = in_valid && (credits_c != '0);
        push_c     = valid && (inflight_q != '0);
        pop_c      = (fifo_cnt_q != '0) && out_ready;
        inflight_d = inflight_q;
        fifo_cnt_d = fifo_cnt_q;
        if (accept_c && !push_c) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!accept_c && push_c) begin
            inflight_d = inflight_q - CW'(1);
        end
        if (push_c && !pop_c) begin
            fifo_cnt_d = fifo_cnt_q + CW'(1);
        end else if (!push_c && pop_c) begin
            fifo_cnt_d = fifo_cnt_q - CW'(1);
        end
    end

    // Request issue, credit counters and result FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            fifo_cnt_q <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            start_q    <= accept_c;
            fifo_cnt_q <= fifo_cnt_d;
            inflight_q <= inflight_d;
            if (accept_c) begin
                a_q <= in_a;
                b_q <= in_b;
            end
            if (push_c) begin
                mem_q[wr_ptr_q] <= y;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    assign in_ready  = (credits_c != '0);
    assign start     = start_q;
    assign a         = a_q;
    assign b         = b_q;
    assign out_valid = (fifo_cnt_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign busy      = (inflight_q != '0) || (fifo_cnt_q != '0);

`ifdef ADD_SEQ_CHECK_EN
    logic [W-1:0]  exp_q [DEPTH];
    logic [PW-1:0] exp_wr_q, exp_rd_q;
    logic          err_q;

    // Expected sums, written on accept; occupancy tracks inflight so it cannot overflow.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            exp_q[exp_wr_q] <= in_a + in_b;
        end
    end

    // Expected-FIFO pointers and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_wr_q <= '0;
            exp_rd_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept_c) begin
                exp_wr_q <= exp_wr_q + PW'(1);
            end
            if (push_c) begin
                exp_rd_q <= exp_rd_q + PW'(1);
                if (y != exp_q[exp_rd_q]) begin
                    err_q <= 1'b1;
                end
            end
            if (valid && (inflight_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_add_seq_initiator.sv
// Self-checking bench for add_seq_initiator with a 2-cycle adder model.
// Build with ADD_SEQ_CHECK_EN defined to also exercise the err output.
module tb_add_seq_initiator;

    localparam int unsigned W     = 20;
    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         start;
    logic [W-1:0] a, b, y;
    logic         valid;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         busy;
`ifdef ADD_SEQ_CHECK_EN
    logic         err;
`endif

    always #5 clk = ~clk;

    add_seq_initiator #(.W(W), .DEPTH(DEPTH), .LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .start     (start),
        .a         (a),
        .b         (b),
        .y         (y),
        .valid     (valid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef ADD_SEQ_CHECK_EN
       ,.err       (err)
`endif
    );

    // Two-stage adder environment; not reset, so results issued before a reset still arrive.
    logic         v1_q = 1'b0, v2_q = 1'b0;
    logic [W-1:0] s1_q = '0, s2_q = '0;
    int           tx_q = 0;
    int           corrupt_idx = -1;
    logic         spur_v = 1'b0;
    logic [W-1:0] spur_y = '0;

    always @(posedge clk) begin
        v1_q <= start;
        s1_q <= a + b + ((start && (tx_q + 1 == corrupt_idx)) ? W'(1) : W'(0));
        if (start) tx_q <= tx_q + 1;
        v2_q <= v1_q;
        s2_q <= s1_q;
    end

    assign valid = v2_q | spur_v;
    assign y     = spur_v ? spur_y : s2_q;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        spur_v   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
    } vec_t;

    vec_t vecs [5];

    // Reference model: operand sums awaiting return, and buffered results.
    logic [W-1:0] aq [$];
    logic [W-1:0] fq [$];
    logic         m_start;
    logic [W-1:0] m_a, m_b;
`ifdef ADD_SEQ_CHECK_EN
    logic         m_err;
`endif

    initial begin
        logic [W-1:0] sums [$];
        int           acc_n;

        vecs[0] = '{a: 20'd5,      b: 20'd7,      sum: 20'd12};
        vecs[1] = '{a: 20'hFFFFF,  b: 20'h00002,  sum: 20'h00001};
        vecs[2] = '{a: 20'h00000,  b: 20'h00000,  sum: 20'h00000};
        vecs[3] = '{a: 20'hFFFFF,  b: 20'hFFFFF,  sum: 20'hFFFFE};
        vecs[4] = '{a: 20'h12345,  b: 20'h54321,  sum: 20'h66666};

        // Asynchronous reset takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_b", 32'(b), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ADD_SEQ_CHECK_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Single transactions: start at N+1, result at N+4, idle afterwards.
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b; out_ready = 1'b1;
            chk("vec_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            chk("vec_start_n1", 32'(start), 32'd1);
            chk("vec_a", 32'(a), 32'(vecs[i].a));
            chk("vec_b", 32'(b), 32'(vecs[i].b));
            @(negedge clk);
            chk("vec_start_n2", 32'(start), 32'd0);
            chk("vec_busy_n2", 32'(busy), 32'd1);
            @(negedge clk);
            chk("vec_out_valid_n3", 32'(out_valid), 32'd0);
            @(negedge clk);
            chk("vec_out_valid_n4", 32'(out_valid), 32'd1);
            chk("vec_out_data", 32'(out_data), 32'(vecs[i].sum));
            @(negedge clk);
            chk("vec_out_valid_n5", 32'(out_valid), 32'd0);
            chk("vec_busy_n5", 32'(busy), 32'd0);
            chk("vec_a_hold", 32'(a), 32'(vecs[i].a));
        end

        // Credit exhaustion with out_ready low, then a single pop.
        out_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = W'(i * 3 + 1);
            in_b = W'(i + 100);
            if (in_ready) begin
                acc_n++;
                sums.push_back(in_a + in_b);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_accepts", 32'(acc_n), 32'(DEPTH));
        repeat (4) @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_head", 32'(out_data), 32'(sums[0]));
        @(negedge clk);
        chk("full_head_stable", 32'(out_data), 32'(sums[0]));
        out_ready = 1'b1;
        chk("full_in_ready_pop_cycle", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        chk("full_in_ready_after_pop", 32'(in_ready), 32'd1);
        for (int j = 1; j < DEPTH; j++) begin
            chk("full_order", 32'(out_data), 32'(sums[j]));
            chk("full_order_valid", 32'(out_valid), 32'd1);
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("full_drained", 32'(out_valid), 32'd0);
        chk("full_busy", 32'(busy), 32'd0);

        // Reset with two requests in flight and one result buffered.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = W'(k + 1); in_b = W'(10);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_a", 32'(a), 32'd0);
        chk("mid_rst_start", 32'(start), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_valid_out_valid", 32'(out_valid), 32'd0);
            chk("late_valid_busy", 32'(busy), 32'd0);
            chk("late_valid_in_ready", 32'(in_ready), 32'd1);
        end
`ifdef ADD_SEQ_CHECK_EN
        chk("late_valid_err", 32'(err), 32'd1);
`endif
        do_reset();

        // Unsolicited adder strobe while idle.
        @(negedge clk);
        spur_v = 1'b1; spur_y = 20'h00123;
        @(negedge clk);
        spur_v = 1'b0;
        chk("spur_out_valid", 32'(out_valid), 32'd0);
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("spur_out_valid_later", 32'(out_valid), 32'd0);
`ifdef ADD_SEQ_CHECK_EN
        chk("spur_err", 32'(err), 32'd1);
        do_reset();

        // Third transaction returns a wrong sum; err rises the cycle after and sticks.
        corrupt_idx = tx_q + 3;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("corrupt_err", 32'(err), (k >= 6) ? 32'd1 : 32'd0);
            chk("corrupt_out_valid", 32'(out_valid), (k >= 4 && k <= 6) ? 32'd1 : 32'd0);
            if (k >= 4 && k <= 6)
                chk("corrupt_out_data", 32'(out_data),
                    32'(W'(100 * (k - 3) + (k - 4) + ((k == 6) ? 1 : 0))));
            if (k < 3) begin
                in_valid = 1'b1; in_a = W'(100 * (k + 1)); in_b = W'(k);
            end else begin
                in_valid = 1'b0;
            end
        end
        corrupt_idx = -1;
`endif
        do_reset();

        // Randomized traffic against the queue-based model.
        aq.delete(); fq.delete();
        m_start = 1'b0; m_a = '0; m_b = '0;
`ifdef ADD_SEQ_CHECK_EN
        m_err = 1'b0;
`endif
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic         m_acc, m_pop, m_v;
            logic [W-1:0] m_y;
            int           credits;
            @(negedge clk);
            credits = int'(DEPTH) - fq.size() - aq.size();
            chk("rnd_in_ready", 32'(in_ready), (credits != 0) ? 32'd1 : 32'd0);
            chk("rnd_out_valid", 32'(out_valid), (fq.size() != 0) ? 32'd1 : 32'd0);
            if (fq.size() != 0) chk("rnd_out_data", 32'(out_data), 32'(fq[0]));
            chk("rnd_busy", 32'(busy), (fq.size() != 0 || aq.size() != 0) ? 32'd1 : 32'd0);
            chk("rnd_start", 32'(start), 32'(m_start));
            chk("rnd_a", 32'(a), 32'(m_a));
            chk("rnd_b", 32'(b), 32'(m_b));
`ifdef ADD_SEQ_CHECK_EN
            chk("rnd_err", 32'(err), 32'(m_err));
`endif
            in_valid  = ($urandom_range(0, 99) < 60);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            out_ready = ($urandom_range(0, 99) < 45);
            spur_v    = !v2_q && ($urandom_range(0, 99) < 3);
            spur_y    = W'($urandom);

            m_acc = in_valid && (credits != 0);
            m_pop = (fq.size() != 0) && out_ready;
            m_v   = v2_q | spur_v;
            m_y   = spur_v ? spur_y : s2_q;
            if (m_pop) void'(fq.pop_front());
            if (m_v) begin
                if (aq.size() == 0) begin
`ifdef ADD_SEQ_CHECK_EN
                    m_err = 1'b1;
`endif
                end else begin
`ifdef ADD_SEQ_CHECK_EN
                    if (aq[0] != m_y) m_err = 1'b1;
`endif
                    void'(aq.pop_front());
                    fq.push_back(m_y);
                end
            end
            m_start = m_acc;
            if (m_acc) begin
                aq.push_back(in_a + in_b);
                m_a = in_a;
                m_b = in_b;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; spur_v = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
